// File: rtl/regfile_wr_arb_pkg.sv
// Shared definitions for the register-file write-port arbiter.
//   REG_AW / REG_DW : default register address / data widths
//   NUM_REGS        : number of architectural registers
//   PC_IDX          : register index that holds the program counter
//   arb_state_e     : arbiter FSM state encoding
package regfile_wr_arb_pkg;

  localparam int REG_AW   = 3;
  localparam int REG_DW   = 16;
  localparam int NUM_REGS = 2 ** REG_AW;
  localparam int PC_IDX   = 7;

  typedef enum logic {
    ST_ARB  = 1'b0,  // round-robin among all valid requesters
    ST_LOCK = 1'b1   // grant reserved for the burst owner
  } arb_state_e;

endpackage

// File: rtl/regfile_wr_arb_rr_pick.sv
// Combinational round-robin priority encoder.
// Searches i_valid starting at i_ptr and wrapping modulo N; the first set
// bit found wins.
//   i_valid : request vector
//   i_ptr   : index holding highest priority this cycle
//   o_grant : one-hot winner (all zero when nothing is valid)
//   o_idx   : binary index of the winner (0 when nothing is valid)
module rr_pick #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_valid,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [PW-1:0] o_idx
);

  logic          w_found;
  logic [PW:0]   w_sum;
  logic [PW-1:0] w_pos;

  always_comb begin
    // NOTE: every variable assigned here gets a default first, so no path
    // through the loop can leave one unassigned and infer a latch.
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_pos   = '0;
    for (int k = 0; k < N; k++) begin
      // (ptr + k) mod N without a divider: one conditional subtract suffices
      w_sum = {1'b0, i_ptr} + (PW+1)'(k);
      if (w_sum >= (PW+1)'(N)) w_sum = w_sum - (PW+1)'(N);
      w_pos = w_sum[PW-1:0];
      if (!w_found && i_valid[w_pos]) begin
        w_found        = 1'b1;
        o_grant[w_pos] = 1'b1;
        o_idx          = w_pos;
      end
    end
  end

endmodule

// File: rtl/regfile_wr_arb.sv
// Register-file write-port arbiter.
// Shares one registered write port among NREQ writeback sources using
// round-robin arbitration, with an optional burst lock that lets one
// requester keep the port for up to MAXBURST back-to-back writes.
//   clk, rst   : clock (rising edge), asynchronous active-low reset
//   req_valid  : per-requester write request
//   req_lock   : requester wants to keep the grant after this transfer
//   req_addr   : per-requester destination register, packed AW each
//   req_data   : per-requester write data, packed DW each
//   req_ready  : one-hot (or zero) grant, combinational
//   regen      : registered register-file write enable
//   inaddr     : registered write address
//   wdata      : registered write data
//   pending    : one-hot of the register being written at the next edge
//   locked     : high while a burst owner holds the port
module regfile_wr_arb
  import regfile_wr_arb_pkg::*;
#(
  parameter int NREQ     = 3,
  parameter int AW       = REG_AW,
  parameter int DW       = REG_DW,
  parameter int MAXBURST = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_lock,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 regen,
  output logic [AW-1:0]        inaddr,
  output logic [DW-1:0]        wdata,
  output logic [2**AW-1:0]     pending,
  output logic                 locked
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(MAXBURST + 1);

  arb_state_e    r_state, w_state_nxt;
  logic [PW-1:0] r_ptr, w_ptr_nxt;
  logic [PW-1:0] r_owner, w_owner_nxt;
  logic [CW-1:0] r_count, w_count_nxt;

  logic          r_regen;
  logic [AW-1:0] r_inaddr;
  logic [DW-1:0] r_wdata;

  logic [NREQ-1:0] w_pick_grant;
  logic [PW-1:0]   w_pick_idx;
  logic [PW-1:0]   w_gidx;
  logic            w_xfer;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] v);
    return (v == PW'(NREQ - 1)) ? '0 : v + PW'(1);
  endfunction

  rr_pick #(.N(NREQ), .PW(PW)) u_pick (
    .i_valid (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_pick_grant),
    .o_idx   (w_pick_idx)
  );

  // Winner index: the owner while locked, otherwise the round-robin pick.
  assign w_gidx = (r_state == ST_LOCK) ? r_owner : w_pick_idx;
  assign w_xfer = |(req_valid & req_ready);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst) begin
      r_state <= ST_ARB;
      r_ptr   <= '0;
      r_owner <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_owner <= w_owner_nxt;
      r_count <= w_count_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = r_owner;
    w_count_nxt = r_count;
    unique case (r_state)
      ST_ARB: begin
        if (w_xfer) begin
          if (req_lock[w_gidx] && (MAXBURST > 1)) begin
            w_state_nxt = ST_LOCK;
            w_owner_nxt = w_gidx;
            w_count_nxt = CW'(1);
          end else begin
            w_ptr_nxt = wrap_inc(w_gidx);
          end
        end
      end
      ST_LOCK: begin
        // While locked the owner transfers whenever it is valid, so a valid
        // owner either extends the burst or ends it with this transfer.
        if (req_valid[r_owner] && req_lock[r_owner] &&
            (int'(r_count) + 1 < MAXBURST)) begin
          w_count_nxt = r_count + CW'(1);
        end else begin
          w_state_nxt = ST_ARB;
          w_ptr_nxt   = wrap_inc(r_owner);
          w_count_nxt = '0;
        end
      end
      default: w_state_nxt = ST_ARB;
    endcase
  end

  // Output logic. Ready is gated by reset so no handshake can be seen while
  // the block is held in reset, even though the picker still sees valids.
  always_comb begin
    req_ready = '0;
    if (rst) begin
      if (r_state == ST_LOCK) req_ready[r_owner] = req_valid[r_owner];
      else                    req_ready = w_pick_grant;
    end
  end

  assign locked = (r_state == ST_LOCK);

  // Registered write port
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: address/data are reset too, so the register file never sees X
    // on its inputs even though regen=0 masks them.
    if (!rst) begin
      r_regen  <= 1'b0;
      r_inaddr <= '0;
      r_wdata  <= '0;
    end else begin
      r_regen <= w_xfer;
      if (w_xfer) begin
        r_inaddr <= req_addr[w_gidx*AW +: AW];
        r_wdata  <= req_data[w_gidx*DW +: DW];
      end
    end
  end

  assign regen  = r_regen;
  assign inaddr = r_inaddr;
  assign wdata  = r_wdata;

  always_comb begin
    pending = '0;
    if (r_regen) pending[r_inaddr] = 1'b1;
  end

endmodule
